// File: rtl/my_top_level.sv
// ---------------------------------------------------------------------------
// my_top_level
//   Registered unsigned adder.  Each rising edge samples io_A and io_B.
//   Their modulo-2^WIDTH sum appears on io_X after LATENCY register stages.
//   There is no handshake, so a new operand pair is accepted on every edge.
//
// Parameters
//   WIDTH    operand and result width
//   LATENCY  register stages from operand sample to io_X (legal range 1..4)
//
// Ports
//   clk    in   system clock; all state updates on the rising edge
//   reset  in   synchronous, active-high; clears every pipeline stage
//   io_A   in   operand A, unsigned, WIDTH bits
//   io_B   in   operand B, unsigned, WIDTH bits
//   io_X   out  registered sum (io_A + io_B) mod 2^WIDTH
// ---------------------------------------------------------------------------
module my_top_level #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_A,
    input  logic [WIDTH-1:0] io_B,
    output logic [WIDTH-1:0] io_X
);

    // The carry-out in bit WIDTH is computed but dropped.
    logic [WIDTH:0]   w_sum_full;
    logic [WIDTH-1:0] w_sum;

    // Stage 0 captures the fresh sum.  Stage LATENCY-1 drives io_X.
    logic [WIDTH-1:0] r_pipe [LATENCY];

    always_comb begin
        w_sum_full = {1'b0, io_A} + {1'b0, io_B};
        w_sum      = w_sum_full[WIDTH-1:0];
    end

    // Reset wins over capture.  Undefined operands present during reset
    // therefore never enter the pipe, and in-flight sums are flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_sum;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign io_X = r_pipe[LATENCY-1];

endmodule

// File: tb/tb_my_top_level.sv
// ---------------------------------------------------------------------------
// tb_my_top_level
//   Runs a LATENCY=1 instance and a LATENCY=3 instance of my_top_level in
//   parallel on shared stimulus.  The reference model records the operand
//   sum and the reset flag for every rising edge.  It derives each expected
//   output from that history: io_X after edge k is zero if reset was high
//   on any of the last LATENCY edges.  Otherwise it is the sum sampled at
//   edge k-LATENCY+1.
// ---------------------------------------------------------------------------
module tb_my_top_level;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a = 8'h12;
    logic [7:0] b = 8'h34;
    logic [7:0] x1;
    logic [7:0] x3;

    always #5 clk = ~clk;

    my_top_level #(.WIDTH(8), .LATENCY(1)) u_lat1 (
        .clk   (clk),
        .reset (reset),
        .io_A  (a),
        .io_B  (b),
        .io_X  (x1)
    );

    my_top_level #(.WIDTH(8), .LATENCY(3)) u_lat3 (
        .clk   (clk),
        .reset (reset),
        .io_A  (a),
        .io_B  (b),
        .io_X  (x3)
    );

    int checks = 0;
    int errors = 0;

    // Per-edge history of what the DUTs sampled.
    int         ncyc = 0;
    logic [7:0] hsum [$];
    bit         hrst [$];
    bit         run_cmp = 1'b1;

    always @(posedge clk) begin
        int s;
        s = (int'(a) + int'(b)) % 256;
        hsum.push_back(8'(s));
        hrst.push_back(reset === 1'b1);
        ncyc++;
    end

    function automatic logic [7:0] model(input int lat, input int k);
        for (int j = 0; j < lat; j++) begin
            if (k - j < 0) return 8'h00;
            if (hrst[k-j]) return 8'h00;
        end
        return hsum[k-lat+1];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    // Compares both instances against the model after every rising edge.
    always @(posedge clk) begin
        int k;
        #1;
        if (run_cmp) begin
            k = ncyc - 1;
            check("model_lat1", x1, model(1, k));
            check("model_lat3", x3, model(3, k));
        end
    end

    // Drive one operand pair and reset value at the falling edge.
    // Then wait until just after the next rising edge.
    task automatic step(input logic [7:0] na, input logic [7:0] nb, input logic nr);
        @(negedge clk);
        a     = na;
        b     = nb;
        reset = nr;
        @(posedge clk);
        #2;
    endtask

    logic [1599:0] word;

    initial begin
        // Reset held for 10 edges with non-zero operands present.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            check("rst_hold_lat1", x1, 8'h00);
            check("rst_hold_lat3", x3, 8'h00);
        end

        // First post-reset edge.
        step(8'h12, 8'h34, 1'b0);
        check("first_sum_lat1", x1, 8'h46);
        check("first_zero_lat3", x3, 8'h00);

        // Basic sums.
        step(8'h03, 8'h04, 1'b0);
        check("basic0", x1, 8'h07);
        step(8'h10, 8'h20, 1'b0);
        check("basic1", x1, 8'h30);
        step(8'h7F, 8'h01, 1'b0);
        check("basic2", x1, 8'h80);

        // Wrap-around.
        step(8'hFF, 8'h01, 1'b0);
        check("wrap_ff01", x1, 8'h00);
        step(8'h80, 8'h80, 1'b0);
        check("wrap_8080", x1, 8'h00);
        step(8'hFF, 8'hFF, 1'b0);
        check("wrap_ffff", x1, 8'hFE);
        step(8'h00, 8'h00, 1'b0);
        check("wrap_0000", x1, 8'h00);

        // LATENCY=3 timing, starting from a fresh reset.
        step(8'hAA, 8'h55, 1'b1);
        check("l3_rst_lat1", x1, 8'h00);
        check("l3_rst_lat3", x3, 8'h00);
        step(8'h01, 8'h02, 1'b0);
        check("l3_pre0", x3, 8'h00);
        step(8'h05, 8'h05, 1'b0);
        check("l3_pre1", x3, 8'h00);
        step(8'h00, 8'h00, 1'b0);
        check("l3_res0", x3, 8'h03);
        step(8'h00, 8'h00, 1'b0);
        check("l3_res1", x3, 8'h0A);

        // Hold: constant operands give a constant output.
        for (int i = 0; i < 4; i++) begin
            step(8'h21, 8'h43, 1'b0);
        end
        check("hold_lat1", x1, 8'h64);
        check("hold_lat3", x3, 8'h64);

        // Streaming 100 random pairs, with a one-edge reset pulse mid-stream.
        for (int i = 0; i < 50; i++) begin
            word[i*32 +: 32] = $urandom;
        end
        for (int i = 0; i < 100; i++) begin
            if (i == 40) begin
                step(word[7:0], word[15:8], 1'b1);
                check("mid_rst_lat1", x1, 8'h00);
                check("mid_rst_lat3", x3, 8'h00);
            end else begin
                step(word[7:0], word[15:8], 1'b0);
            end
            word = word >> 16;
        end

        // Flush the LATENCY=3 pipe.
        for (int i = 0; i < 4; i++) begin
            step(8'h00, 8'h00, 1'b0);
        end

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
